// File: rtl/seq_alu_pkg.sv
// Shared opcodes, error codes and FSM state encoding for seq_alu.
package seq_alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_alu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, WIDTH iterations.
// done_o is high in the cycle whose closing edge performs the last iteration.
module seq_alu_divider
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             last;

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (start_i && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      // Keep the trial difference only when the divisor fits.
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CW'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign done_o      = busy_q && last;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: add/sub/mul/div with start/done handshake.
// Define SEQ_ALU_MODULO_EN to enable command 5 (modulo); otherwise it is illegal.
//
// Handshake: start is sampled on a rising edge only while busy=0 (state IDLE);
// busy=1 in every other state; done is a one-cycle pulse on which result and
// error become valid, and they hold until the next operation completes.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         command,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [1:0]         error,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [1:0]         error_q, error_d;
  logic               done_q, done_d;

  logic               div_start;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               is_div_in;
  logic               cin;
  logic [WIDTH-1:0]   bx;
  logic [WIDTH:0]     sum_full;
  logic               carry_msb;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;

`ifdef SEQ_ALU_MODULO_EN
  assign is_div_in = (command == OP_DIV) || (command == OP_MOD);
`else
  assign is_div_in = (command == OP_DIV);
  logic unused_rem;
  assign unused_rem = ^div_rem;
`endif

  // Subtract as a + ~b + 1 so overflow falls out of the MSB carries.
  assign cin       = (cmd_q == OP_SUB);
  assign bx        = cin ? ~b_q : b_q;
  assign sum_full  = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
  assign carry_msb = a_q[WIDTH-1] ^ bx[WIDTH-1] ^ sum_full[WIDTH-1];

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    error_d   = error_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d = command;
          a_d   = operand_a;
          b_d   = operand_b;
          cnt_d = '0;
          acc_d = {{WIDTH{1'b0}}, operand_b};
          if (command == OP_MUL) begin
            state_d = S_MUL;
          end else if (is_div_in && (operand_b != '0)) begin
            state_d   = S_DIV;
            div_start = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DIV: begin
        if (div_done) state_d = S_DONE;
      end
      S_DONE: begin
        done_d   = 1'b1;
        state_d  = S_IDLE;
        result_d = '0;
        error_d  = ERR_OK;
        case (cmd_q)
          OP_NOP: ;
          OP_ADD, OP_SUB: begin
            result_d = {{WIDTH{sum_full[WIDTH-1]}}, sum_full[WIDTH-1:0]};
            if (sum_full[WIDTH] != carry_msb) error_d = ERR_OVF;
          end
          OP_MUL: result_d = acc_q;
          OP_DIV: begin
            if (b_q == '0) error_d = ERR_DIV0;
            else result_d = {{WIDTH{1'b0}}, div_quo};
          end
`ifdef SEQ_ALU_MODULO_EN
          OP_MOD: begin
            if (b_q == '0) error_d = ERR_DIV0;
            else result_d = {{WIDTH{1'b0}}, div_rem};
          end
`endif
          default: error_d = ERR_ILLEGAL;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= ERR_OK;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  seq_alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (operand_a),
    .divisor_i   (operand_b),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule
